mod_osc_phase: RTL and testbench

Phase-accumulator oscillator core that generates the per-sample angle stream consumed by the 16-bit sine stage. It advances a wide phase accumulator once per sample tick by a frequency tuning word (FTW), applies a phase offset, and presents a registered signed 16-bit angle with a valid pulse. It also supports hard sync, wrap reporting for oscillator chaining, and an optional frequency glide (portamento) engine.

---
 rtl/mod_osc_phase.sv | 144 ++++++++++++++
 tb/tb_mod_osc_phase.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_osc_phase.sv
// Phase-accumulator oscillator: wide accumulator advanced per sample tick, signed 16-bit angle out.
// Optional frequency glide (portamento) engine compiled in with ORPHEUS_OSC_GLIDE_EN.
module mod_osc_phase #(
  parameter int ACC_W       = 32,
  parameter int GLIDE_SHIFT = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic [ACC_W-1:0] i_ftw,
  input  logic             i_ftw_valid,
  output logic             o_ftw_ready,
  input  logic             i_sync,
  input  logic [15:0]      i_phase_off,
  output logic [15:0]      o_angle,
  output logic             o_angle_valid,
  output logic             o_wrap
);

  if (ACC_W < 16 || GLIDE_SHIFT < 0 || GLIDE_SHIFT >= ACC_W) begin : g_bad_param
    $error("mod_osc_phase: ACC_W must be >= 16 and GLIDE_SHIFT in [0, ACC_W)");
  end

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] ftw_cur_q, ftw_cur_d;
  logic             sync_pend_q, sync_pend_d;
  logic [15:0]      angle_q, angle_d;
  logic             angle_valid_q, angle_valid_d;
  logic             wrap_q, wrap_d;
  logic [ACC_W:0]   acc_sum;
  logic             accept;

  // Tick path always sees ftw_cur_q, so an FTW change (accept or glide step) lands on later ticks.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    acc_d         = acc_q;
    sync_pend_d   = sync_pend_q;
    angle_d       = angle_q;
    angle_valid_d = 1'b0;
    wrap_d        = 1'b0;
    acc_sum       = {1'b0, acc_q} + {1'b0, ftw_cur_q};
    if (i_tick) begin
      angle_valid_d = 1'b1;
      sync_pend_d   = 1'b0;
      if (i_sync || sync_pend_q) begin
        acc_d   = '0;
        angle_d = i_phase_off;
      end else begin
        acc_d   = acc_sum[ACC_W-1:0];
        angle_d = acc_sum[ACC_W-1 -: 16] + i_phase_off;
        wrap_d  = acc_sum[ACC_W];
      end
    end else if (i_sync) begin
      sync_pend_d = 1'b1;
    end
  end

`ifdef ORPHEUS_OSC_GLIDE_EN
  typedef enum logic {IDLE, GLIDE} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] ftw_tgt_q, ftw_tgt_d;
  logic [ACC_W:0]   diff, diff_neg;
  logic [ACC_W-1:0] mag, step;

  assign o_ftw_ready = (state_q == IDLE);
  assign accept      = i_ftw_valid && o_ftw_ready;

  always_comb begin
    state_d   = state_q;
    ftw_cur_d = ftw_cur_q;
    ftw_tgt_d = ftw_tgt_q;
    diff      = {1'b0, ftw_tgt_q} - {1'b0, ftw_cur_q};
    diff_neg  = -diff;
    mag       = diff[ACC_W] ? diff_neg[ACC_W-1:0] : diff[ACC_W-1:0];
    step      = mag >> GLIDE_SHIFT;
    if (step == '0) step = {{(ACC_W-1){1'b0}}, 1'b1};
    case (state_q)
      IDLE: begin
        if (accept && i_ftw != ftw_cur_q) begin
          ftw_tgt_d = i_ftw;
          state_d   = GLIDE;
        end
      end
      GLIDE: begin
        if (i_tick) begin
          // Clamp the final step onto the target so the glide never overshoots.
          if (step >= mag) begin
            ftw_cur_d = ftw_tgt_q;
            state_d   = IDLE;
          end else if (diff[ACC_W]) begin
            ftw_cur_d = ftw_cur_q - step;
          end else begin
            ftw_cur_d = ftw_cur_q + step;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      ftw_tgt_q <= '0;
    end else begin
      state_q   <= state_d;
      ftw_tgt_q <= ftw_tgt_d;
    end
  end
`else
  assign o_ftw_ready = 1'b1;
  assign accept      = i_ftw_valid;

  always_comb begin
    ftw_cur_d = ftw_cur_q;
    if (accept) ftw_cur_d = i_ftw;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!i_rst_n) begin
      acc_q         <= '0;
      ftw_cur_q     <= '0;
      sync_pend_q   <= 1'b0;
      angle_q       <= '0;
      angle_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      ftw_cur_q     <= ftw_cur_d;
      sync_pend_q   <= sync_pend_d;
      angle_q       <= angle_d;
      angle_valid_q <= angle_valid_d;
      wrap_q        <= wrap_d;
    end
  end

  assign o_angle       = angle_q;
  assign o_angle_valid = angle_valid_q;
  assign o_wrap        = wrap_q;

endmodule

// File: tb/tb_mod_osc_phase.sv
// Self-checking bench for mod_osc_phase: directed scenarios plus random traffic against an
// arithmetic reference model; glide scenarios run when ORPHEUS_OSC_GLIDE_EN is defined.
module tb_mod_osc_phase;
  localparam int ACC_W       = 32;
  localparam int GLIDE_SHIFT = 8;
  localparam longint unsigned TURN = 64'd1 << ACC_W;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_tick = 1'b0;
  logic [31:0] i_ftw = '0;
  logic        i_ftw_valid = 1'b0;
  logic        o_ftw_ready;
  logic        i_sync = 1'b0;
  logic [15:0] i_phase_off = '0;
  logic [15:0] o_angle;
  logic        o_angle_valid;
  logic        o_wrap;

  int checks = 0;
  int errors = 0;

  // Reference model state, plain integers.
  longint unsigned m_acc, m_ftw, m_tgt;
  bit              m_pend, m_gliding;
  logic [15:0]     m_angle;
  bit              m_valid, m_wrap;

  mod_osc_phase #(.ACC_W(ACC_W), .GLIDE_SHIFT(GLIDE_SHIFT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tick(i_tick), .i_ftw(i_ftw),
    .i_ftw_valid(i_ftw_valid), .o_ftw_ready(o_ftw_ready), .i_sync(i_sync),
    .i_phase_off(i_phase_off), .o_angle(o_angle), .o_angle_valid(o_angle_valid),
    .o_wrap(o_wrap)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    return !m_gliding;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_ftw = 0; m_tgt = 0; m_pend = 0; m_gliding = 0;
    m_angle = '0; m_valid = 0; m_wrap = 0;
  endtask

  task automatic model_step(input bit tick, input bit sync, input bit accept,
                            input longint unsigned ftw, input logic [15:0] off);
    longint unsigned sum, mag, step;
    bit up;
    bit was_gliding = m_gliding;
    m_valid = tick;
    m_wrap  = 0;
    if (tick) begin
      if (sync || m_pend) begin
        m_acc   = 0;
        m_angle = off;
      end else begin
        sum     = m_acc + m_ftw;
        m_wrap  = (sum >= TURN);
        m_acc   = sum % TURN;
        m_angle = 16'((m_acc >> (ACC_W - 16)) + off);
      end
      m_pend = 0;
    end else if (sync) begin
      m_pend = 1;
    end
`ifdef ORPHEUS_OSC_GLIDE_EN
    if (was_gliding && tick) begin
      up   = (m_tgt > m_ftw);
      mag  = up ? m_tgt - m_ftw : m_ftw - m_tgt;
      step = mag / (64'd1 << GLIDE_SHIFT);
      if (step < 1) step = 1;
      if (step >= mag) begin
        m_ftw = m_tgt;
        m_gliding = 0;
      end else begin
        m_ftw = up ? m_ftw + step : m_ftw - step;
      end
    end
    if (accept && ftw != m_ftw) begin
      m_tgt = ftw;
      m_gliding = 1;
    end
`else
    if (was_gliding) m_gliding = 0;
    if (accept) m_ftw = ftw;
`endif
  endtask

  // One clock: inputs driven at the falling edge, outputs checked at the next falling edge.
  task automatic cyc(input bit tick, input bit sync, input bit fv,
                     input logic [31:0] ftw, input logic [15:0] off);
    bit acc_ok;
    i_tick = tick; i_sync = sync; i_ftw_valid = fv; i_ftw = ftw; i_phase_off = off;
    #1;
    chk("ftw_ready", {31'd0, o_ftw_ready}, {31'd0, model_ready()});
    acc_ok = fv && model_ready();
    @(posedge i_clk);
    model_step(tick, sync, acc_ok, longint'(ftw), off);
    @(negedge i_clk);
    chk("angle_valid", {31'd0, o_angle_valid}, {31'd0, m_valid});
    chk("wrap", {31'd0, o_wrap}, {31'd0, m_wrap});
    chk("angle", {16'd0, o_angle}, {16'd0, m_angle});
    chk("ftw_cur", dut.ftw_cur_q, 32'(m_ftw));
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear immediately.
  task automatic do_reset();
    i_tick = 0; i_sync = 0; i_ftw_valid = 0;
    #2 i_rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_angle", {16'd0, o_angle}, 32'h0);
    chk("rst_valid", {31'd0, o_angle_valid}, 32'h0);
    chk("rst_wrap", {31'd0, o_wrap}, 32'h0);
    chk("rst_ready", {31'd0, o_ftw_ready}, 32'h1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge i_clk);
    do_reset();

    // First tick after reset: angle equals the offset.
    cyc(1, 0, 0, 32'h0, 16'h1234);
    chk("first_tick_off", {16'd0, o_angle}, 32'h1234);

    // Linear ramp.
    do_reset();
    cyc(0, 0, 1, 32'h0001_0000, 16'h0);
`ifdef ORPHEUS_OSC_GLIDE_EN
    for (int i = 0; i < 4000 && m_gliding; i++) cyc(1, 0, 0, 32'h0, 16'h0);
    do_reset();
    m_ftw = 0;
`else
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 0, 0, 32'h0, 16'h0);
      chk("ramp", {16'd0, o_angle}, 32'(i));
    end

    // Wrap, then hard sync pulsed two cycles ahead of the next tick.
    do_reset();
    cyc(0, 0, 1, 32'h4000_0000, 16'h0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 32'h0, 16'h0);
    chk("wrap_4th", {31'd0, o_wrap}, 32'h1);
    cyc(1, 0, 0, 32'h0, 16'h0);
    cyc(1, 0, 0, 32'h0, 16'h0);
    chk("pre_sync", {16'd0, o_angle}, 32'h8000);
    cyc(0, 1, 0, 32'h0, 16'h1000);
    cyc(0, 0, 0, 32'h0, 16'h1000);
    cyc(1, 0, 0, 32'h0, 16'h1000);
    chk("sync_angle", {16'd0, o_angle}, 32'h1000);
    cyc(1, 0, 0, 32'h0, 16'h1000);
    chk("post_sync", {16'd0, o_angle}, 32'h5000);

    // FTW accept colliding with a tick.
    do_reset();
    cyc(0, 0, 1, 32'h0001_0000, 16'h0);
    cyc(1, 0, 1, 32'h0002_0000, 16'h0);
    chk("collide_a", {16'd0, o_angle}, 32'h0001);
    cyc(1, 0, 0, 32'h0, 16'h0);
    chk("collide_b", {16'd0, o_angle}, 32'h0003);
`endif

`ifdef ORPHEUS_OSC_GLIDE_EN
    // Glide from 0 to 0x1000.
    do_reset();
    cyc(0, 0, 1, 32'h0000_1000, 16'h0);
    cyc(0, 0, 0, 32'h0, 16'h0);
    chk("glide_ready_low", {31'd0, o_ftw_ready}, 32'h0);
    cyc(1, 0, 0, 32'h0, 16'h0);
    chk("glide_t1", dut.ftw_cur_q, 32'h10);
    cyc(1, 0, 0, 32'h0, 16'h0);
    chk("glide_t2", dut.ftw_cur_q, 32'h1F);
    cyc(1, 0, 0, 32'h0, 16'h0);
    chk("glide_t3", dut.ftw_cur_q, 32'h2E);
    for (int i = 0; i < 5000 && m_gliding; i++) begin
      cyc(1, 0, 0, 32'h0, 16'h0);
      chk("glide_no_overshoot", {31'd0, dut.ftw_cur_q <= 32'h1000}, 32'h1);
    end
    chk("glide_arrived", dut.ftw_cur_q, 32'h1000);
    cyc(0, 0, 0, 32'h0, 16'h0);
    chk("glide_ready_back", {31'd0, o_ftw_ready}, 32'h1);
`endif

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 2) == 0, ($urandom % 8) == 0, ($urandom % 4) == 0,
          ($urandom % 2) ? $urandom : ($urandom & 32'h000F_FFFF), 16'($urandom));
    end

    // Reset while a sync is pending: the pending sync is discarded.
    cyc(0, 1, 0, 32'h0, 16'h0);
    do_reset();
    cyc(1, 0, 0, 32'h0, 16'h0BEE);
    chk("rst_discard_sync", {16'd0, o_angle}, 32'h0BEE);
    cyc(1, 0, 0, 32'h0, 16'h0BEE);
    chk("rst_ftw_zero", {16'd0, o_angle}, 32'h0BEE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
